// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared constants and FSM state type for fifo_stream_reader
// Contents: default DATA_WIDTH/LINE_LEN and the IDLE/STREAM/DRAIN state enum.
package fifo_reader_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int LINE_LEN_DEF = 1280;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry output buffer; head entry drives the stream registers
// Ports: clk, rst (sync active-high), push/din (write), pop (head consumed),
//        dout/valid (head entry), occ (entries held, 0..2).
module stream_skid_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [1:0]    occ
);
  logic [DW-1:0] d1;
  logic          v1;
  assign occ = {valid & v1, valid ^ v1};
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
      d1    <= '0;
      v1    <= 1'b0;
    end else if (pop) begin
      // head leaves: tail (if any) moves up, an incoming word fills behind it
      valid <= v1 | push;
      v1    <= v1 & push;
      if (v1 | push) dout <= v1 ? d1 : din;
      if (v1) d1 <= din;
    end else if (push) begin
      if (valid) begin
        d1 <= din;
        v1 <= 1'b1;
      end else begin
        dout  <= din;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains sync_fifo into a gapless valid/ready stream framed in LINE_LEN-word lines
// Ports: clk, rst (sync active-high); fifo_rd_en/fifo_rd_data/fifo_rd_empty/fifo_almost_empty
//        (FIFO read side, one-cycle read latency); m_valid/m_ready/m_data/m_last (stream);
//        line_done (pulse the cycle after the m_last handshake).
// Macro FIFO_STREAM_READER_LINE_EN: defined gives line framing (counters, DRAIN, m_last,
//        line_done); undefined gives a plain FIFO-to-stream reader with m_last/line_done tied low.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  line_done
);
  state_t     state;
  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  if (LINE_LEN < 1) begin : g_len_check
    $error("LINE_LEN must be at least 1");
  end
  assign pop = m_valid & m_ready;
  // a read is only issued when the buffer is guaranteed a free slot when its data lands
  assign fifo_rd_en = (state == STREAM) & ~fifo_rd_empty &
                      (({1'b0, occ} + {2'b0, inflight}) <= ({2'b0, pop} + 3'd1));
  stream_skid_buf #(.DW(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (fifo_rd_data),
    .pop   (pop),
    .dout  (m_data),
    .valid (m_valid),
    .occ   (occ)
  );
`ifdef FIFO_STREAM_READER_LINE_EN
  localparam int CW = $clog2(LINE_LEN + 1);
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] out_cnt;
  assign m_last = m_valid & (out_cnt == CW'(LINE_LEN - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      line_done <= 1'b0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
    end else begin
      inflight  <= fifo_rd_en;
      line_done <= pop & m_last;
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE:    if (!fifo_almost_empty) state <= STREAM;
        STREAM:  if (fifo_rd_en && rd_cnt == CW'(LINE_LEN - 1)) state <= DRAIN;
        DRAIN:   if (pop && m_last) begin
          // IDLE is passed through in the same cycle when the next burst is ready,
          // so the next line's first read lands in the line_done cycle
          state   <= fifo_almost_empty ? IDLE : STREAM;
          rd_cnt  <= '0;
          out_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign m_last    = 1'b0;
  assign line_done = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (state == IDLE && !fifo_almost_empty) state <= STREAM;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed/randomized bench with a FIFO model and an in-order scoreboard
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int L = 1280;
`ifdef FIFO_STREAM_READER_LINE_EN
  localparam int LE = 1;
`else
  localparam int LE = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic fifo_rd_empty = 1'b1;
  logic fifo_almost_empty = 1'b1;
  logic m_valid;
  logic m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic m_last;
  logic line_done;
  fifo_stream_reader #(.DATA_WIDTH(DW), .LINE_LEN(L)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_empty     (fifo_rd_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .line_done         (line_done)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  always @(posedge clk) if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
  int n_cmp = 0, n_err = 0, cyc = 0, pos = 0, acc = 0;
  int nl, nld, n_rd, n_valid, first_rd, first_v, first_acc, last_acc, lw, n_reiss, rdy_mode, n0;
  bit rst_req, ae_hold, hold, ld_exp, prev_ae;
  logic [DW-1:0] held;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr_stats();
    nl = 0; nld = 0; n_rd = 0; n_valid = 0; first_rd = -1; first_v = -1;
    first_acc = -1; last_acc = -1; lw = -1; n_reiss = 0; acc = 0;
  endtask
  task automatic monitor();
    logic el;
    el = (LE == 1) && m_valid && pos == L - 1;
    chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_rd_empty), 0);
    chk("m_last", 32'(m_last), 32'(el));
    chk("line_done", 32'(line_done), 32'(ld_exp));
    if (hold) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", 32'(m_data), 32'(held));
    end
`ifdef FIFO_STREAM_READER_LINE_EN
    if (line_done && !prev_ae && !fifo_rd_empty) begin
      chk("reissue_in_line_done", 32'(fifo_rd_en), 1);
      n_reiss++;
    end
`endif
    if (fifo_rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid) begin
      n_valid++;
      if (first_v < 0) first_v = cyc;
    end
    if (line_done) nld++;
    hold = !rst && m_valid && !m_ready;
    held = m_data;
    ld_exp = !rst && m_valid && m_ready && el;
    if (!rst && m_valid && m_ready) begin
      chk("word_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      if (m_last) begin
        nl++;
        lw = int'(m_data);
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      acc++;
      pos = (pos + 1) % L;
    end
    prev_ae = fifo_almost_empty;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_req;
    fifo_rd_empty = (fq.size() == 0);
    fifo_almost_empty = ae_hold || (fq.size() < 4);
    m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
    @(negedge clk);
    monitor();
    cyc++;
  endtask
  task automatic run(input int n, input int lim);
    int tgt;
    tgt = acc + n;
    for (int i = 0; i < lim && acc < tgt; i++) step();
    chk("cycle_budget", 32'(acc >= tgt), 1);
  endtask
  task automatic do_reset();
    ae_hold = 1;
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_line_done", 32'(line_done), 0);
    fq.delete();
    exp_q.delete();
    pos = 0;
  endtask
  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask
  initial begin
    rdy_mode = 0;
    clr_stats();
    do_reset();
    // almost_empty held high with data present: nothing may be read
    for (int i = 0; i < 50; i++) push(DW'($urandom));
    clr_stats();
    repeat (60) step();
    chk("ae_hold_rd", 32'(n_rd), 0);
    chk("ae_hold_valid", 32'(n_valid), 0);
    do_reset();
    // full line, m_ready high: start latency, gapless, single m_last on 1279
    for (int i = 0; i < L; i++) push(DW'(i));
    repeat (2) step();
    clr_stats();
    ae_hold = 0;
    n0 = cyc;
    run(L, 3000);
    repeat (3) step();
    chk("first_rd_cycle", 32'(first_rd), 32'(n0 + 1));
    chk("first_valid_cycle", 32'(first_v), 32'(n0 + 3));
    chk("gapless_span", 32'(last_acc - first_acc), 32'(L - 1));
    chk("reads_issued", 32'(n_rd), 32'(L));
    chk("last_count", 32'(nl), 32'(LE));
    chk("line_done_count", 32'(nld), 32'(LE));
    chk("last_word", 32'(lw), (LE == 1) ? 32'(L - 1) : 32'hffffffff);
    chk("all_words_out", 32'(exp_q.size()), 0);
    do_reset();
    // m_ready toggling 1010...
    rdy_mode = 1;
    for (int i = 0; i < L; i++) push(DW'(i));
    clr_stats();
    ae_hold = 0;
    run(L, 4000);
    repeat (3) step();
    chk("toggle_last_count", 32'(nl), 32'(LE));
    chk("toggle_line_done", 32'(nld), 32'(LE));
    chk("toggle_last_word", 32'(lw), (LE == 1) ? 32'(L - 1) : 32'hffffffff);
    chk("toggle_all_out", 32'(exp_q.size()), 0);
    rdy_mode = 0;
    do_reset();
    // FIFO runs dry after word 600, refilled 20 cycles later
    for (int i = 0; i <= 600; i++) push(DW'(i));
    clr_stats();
    ae_hold = 0;
    run(601, 2000);
    repeat (20) step();
    for (int i = 601; i < L; i++) push(DW'(i));
    run(L - 601, 2000);
    repeat (3) step();
    chk("bubble_seen", 32'(last_acc - first_acc > L - 1), 1);
    chk("underflow_last_count", 32'(nl), 32'(LE));
    chk("underflow_last_word", 32'(lw), (LE == 1) ? 32'(L - 1) : 32'hffffffff);
    chk("underflow_all_out", 32'(exp_q.size()), 0);
    do_reset();
    // reset at word 300 discards the partial line; next line frames from zero
    for (int i = 0; i < L; i++) push(DW'($urandom));
    clr_stats();
    ae_hold = 0;
    run(300, 1000);
    do_reset();
    chk("partial_no_last", 32'(nl), 0);
    for (int i = 0; i < L; i++) push(DW'($urandom));
    clr_stats();
    ae_hold = 0;
    run(L, 3000);
    repeat (3) step();
    chk("after_rst_last_count", 32'(nl), 32'(LE));
    chk("after_rst_all_out", 32'(exp_q.size()), 0);
    do_reset();
    // two back-to-back lines
    for (int i = 0; i < 2 * L; i++) push(DW'($urandom));
    clr_stats();
    ae_hold = 0;
    run(2 * L, 6000);
    repeat (3) step();
    chk("b2b_last_count", 32'(nl), 32'(2 * LE));
    chk("b2b_line_done", 32'(nld), 32'(2 * LE));
    chk("b2b_all_out", 32'(exp_q.size()), 0);
`ifdef FIFO_STREAM_READER_LINE_EN
    chk("b2b_reissue_count", 32'(n_reiss), 1);
`endif
    do_reset();
    // random data and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 500; i++) push(DW'($urandom));
    clr_stats();
    ae_hold = 0;
    run(500, 3000);
    repeat (3) step();
    chk("rand_all_out", 32'(exp_q.size()), 0);
    chk("rand_fifo_drained", 32'(fq.size()), 0);
    chk("rand_no_last", 32'(nl), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
